mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: port A (instruction fetch, read-only) and port B (data
// read/write) share one downstream memory; ties alternate using a last-grant flag.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read_a,
    input  logic [ADDR_W-1:0]     address_a,
    output logic                  resp_a,
    output logic [DATA_W-1:0]     rdata_a,
    input  logic                  read_b,
    input  logic                  write_b,
    input  logic [ADDR_W-1:0]     address_b,
    input  logic [DATA_W-1:0]     wdata_b,
    input  logic [DATA_W/8-1:0]   wmask_b,
    output logic                  resp_b,
    output logic [DATA_W-1:0]     rdata_b,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_resp,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [CNT_W-1:0]      conflict_count
);

    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_A = 2'd1,
        BUSY_B = 2'd2
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic                last_grant_b_r;   // 1'b1: port B won the most recent grant
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [MASK_W-1:0]   wmask_r;
    logic                op_write_r;
    logic [CNT_W-1:0]    conflict_count_r;

    logic                req_a_s;
    logic                req_b_s;
    logic                grant_a_s;
    logic                grant_b_s;

    assign req_a_s = read_a;
    assign req_b_s = read_b | write_b;

    // Arbitration and next-state decision
    always_comb begin
        next_state_s = state_r;
        grant_a_s    = 1'b0;
        grant_b_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_a_s && req_b_s) begin
                    if (last_grant_b_r) begin
                        grant_a_s = 1'b1;
                    end else begin
                        grant_b_s = 1'b1;
                    end
                end else if (req_a_s) begin
                    grant_a_s = 1'b1;
                end else if (req_b_s) begin
                    grant_b_s = 1'b1;
                end else begin
                    grant_a_s = 1'b0;
                end
                if (grant_a_s) begin
                    next_state_s = BUSY_A;
                end else if (grant_b_s) begin
                    next_state_s = BUSY_B;
                end else begin
                    next_state_s = IDLE;
                end
            end
            BUSY_A, BUSY_B: begin
                if (mem_resp) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State and grant-history register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            last_grant_b_r <= 1'b1;
        end else begin
            state_r <= next_state_s;
            if (grant_a_s) begin
                last_grant_b_r <= 1'b0;
            end else if (grant_b_s) begin
                last_grant_b_r <= 1'b1;
            end else begin
                last_grant_b_r <= last_grant_b_r;
            end
        end
    end

    // Capture the winner's request; held stable for the whole transaction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_r     <= {ADDR_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            wmask_r    <= {MASK_W{1'b0}};
            op_write_r <= 1'b0;
        end else if (grant_a_s) begin
            addr_r     <= address_a;
            wdata_r    <= {DATA_W{1'b0}};
            wmask_r    <= {MASK_W{1'b0}};
            op_write_r <= 1'b0;
        end else if (grant_b_s) begin
            addr_r     <= address_b;
            wdata_r    <= wdata_b;
            wmask_r    <= wmask_b;
            op_write_r <= write_b;
        end else begin
            addr_r     <= addr_r;
            wdata_r    <= wdata_r;
            wmask_r    <= wmask_r;
            op_write_r <= op_write_r;
        end
    end

    // Saturating count of IDLE cycles where both ports contend
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflict_count_r <= {CNT_W{1'b0}};
        end else if ((state_r == IDLE) && req_a_s && req_b_s
                     && (conflict_count_r != {CNT_W{1'b1}})) begin
            conflict_count_r <= conflict_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            conflict_count_r <= conflict_count_r;
        end
    end

    // Responses pass straight through so the requester sees completion in the mem_resp cycle
    assign resp_a  = (state_r == BUSY_A) & mem_resp;
    assign resp_b  = (state_r == BUSY_B) & mem_resp;
    assign rdata_a = (state_r == BUSY_A) ? mem_rdata : {DATA_W{1'b0}};
    assign rdata_b = (state_r == BUSY_B) ? mem_rdata : {DATA_W{1'b0}};

    assign mem_read       = (state_r == BUSY_A) | ((state_r == BUSY_B) & ~op_write_r);
    assign mem_write      = (state_r == BUSY_B) & op_write_r;
    assign mem_address    = addr_r;
    assign mem_wdata      = wdata_r;
    assign mem_wmask      = wmask_r;
    assign conflict_count = conflict_count_r;

endmodule
